// File: rtl/ack_bus_if.sv
// Acknowledge-bus requester interface.
// Groups the completion strobe, the arbiter grant, the open-drain pull
// enables, the sideband request and the status outputs of one requester.
//   ack_pulse        one-cycle completion strobe from the owning module
//   ack_ready        one-hot grant from the arbiter for this source
//   ack_valid_n_pull 1 = pull ack_valid_n_bus low
//   ack_id_pull      per bit, 1 = pull that ack_id_bus bit low
//   req              sideband request to the arbiter
//   pending          acks queued but not yet granted
//   overflow_err     sticky, a pulse was lost because the queue was full
//   timeout_err      sticky, an ack was dropped after waiting too long
// modport master: the requester itself; modport slave: its surroundings.
interface ack_bus_if #(
  parameter int CNT_W = 3
);
  logic             ack_pulse;
  logic             ack_ready;
  logic             ack_valid_n_pull;
  logic [1:0]       ack_id_pull;
  logic             req;
  logic [CNT_W-1:0] pending;
  logic             overflow_err;
  logic             timeout_err;

  modport master (
    input  ack_pulse, ack_ready,
    output ack_valid_n_pull, ack_id_pull, req, pending, overflow_err, timeout_err
  );

  modport slave (
    output ack_pulse, ack_ready,
    input  ack_valid_n_pull, ack_id_pull, req, pending, overflow_err, timeout_err
  );
endinterface

// File: rtl/ack_bus_requester.sv
// Per-module front end of the shared open-drain acknowledge bus.
// Queues completion pulses in a saturating pending counter and, for each
// queued ack, drives the wired-AND bus plus the sideband request until the
// arbiter grants it. Each grant is followed by one idle GAP cycle so the
// bus floats back high before the next assertion.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ack_bus_if.master (pulse/grant in; pulls, req, pending, errors out)
// All outputs are decoded from registered state only.
module ack_bus_requester #(
  parameter logic [1:0] SOURCE_ID = 2'b01,
  parameter int         CNT_W     = 3,
  parameter int         TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ack_bus_if.master     bus
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ovf_q, ovf_d;
  logic             tout_q, tout_d;

  logic grant;
  logic timeout_hit;
  logic inc;
  logic dec;

  // State register.
  // NOTE: the reset branch is in the sensitivity list so the pulls release
  // the instant rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
      tout_q    <= tout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    pending_d = pending_q;
    timer_d   = '0;
    ovf_d     = ovf_q;

    // ack_ready only counts while we are actually requesting.
    grant       = bus.ack_ready && (state_q == REQ);
    // Grant wins over a timeout in the same cycle.
    timeout_hit = (state_q == REQ) && !bus.ack_ready && (timer_q == TMR_LAST);
    inc         = bus.ack_pulse;
    dec         = grant || timeout_hit;
    tout_d      = tout_q || timeout_hit;

    if (inc && !dec) begin
      if (pending_q == PEND_MAX) ovf_d = 1'b1;   // pulse is lost
      else                       pending_d = pending_q + 1'b1;
    end else if (dec && !inc) begin
      pending_d = pending_q - 1'b1;
    end

    unique case (state_q)
      IDLE: if (pending_d != '0) state_d = REQ;
      REQ: begin
        if (dec) state_d = GAP;
        else     timer_d = timer_q + 1'b1;
      end
      GAP:     state_d = (pending_q != '0) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.req              = (state_q == REQ);
    bus.ack_valid_n_pull = (state_q == REQ);
    bus.ack_id_pull      = (state_q == REQ) ? ~SOURCE_ID : 2'b00;
    bus.pending          = pending_q;
    bus.overflow_err     = ovf_q;
    bus.timeout_err      = tout_q;
  end

endmodule
